// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM state encoding and buffer entry layout for the fetch stage
package fetch_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: first-word fall-through buffer with clear; head holds its last value while empty
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             do_push, do_pop;
  always_comb begin
    valid   = count_q != '0;
    do_pop  = pop & valid;
    do_push = push & ((count_q != CW'(DEPTH)) | do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_ptr_q] = din;
    wr_ptr_d = clear ? '0 : wr_ptr_q + PW'(do_push);
    rd_ptr_d = clear ? '0 : rd_ptr_q + PW'(do_pop);
    count_d  = clear ? '0 : count_q + CW'(do_push) - CW'(do_pop);
    // remember whatever is on the head so the outputs freeze once the buffer drains
    last_d = valid ? mem_q[rd_ptr_q] : last_q;
    dout   = valid ? mem_q[rd_ptr_q] : last_q;
    count  = count_q;
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetcher feeding decode through a small FWFT buffer
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_inc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t                     state_q, state_d;
  logic [ADDR_W-1:0]          req_pc_q, req_pc_d;
  logic [CW-1:0]              count;
  logic                       pop, push, space_idle, space_push;
  logic [ADDR_W+DATA_W-1:0]   head;
  always_comb begin
    pop        = instr_valid & instr_ready;
    push       = (state_q == WAIT) & mem_rvalid & ~flush;
    space_idle = (count - CW'(pop)) < CW'(FIFO_DEPTH);
    space_push = (count + CW'(1) - CW'(pop)) < CW'(FIFO_DEPTH);
    mem_req    = state_q == REQ;
    mem_addr   = pc;
    pc_inc     = 1'b0;
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    case (state_q)
      IDLE:  if (fetch_en & ~flush & space_idle) state_d = REQ;
      REQ:
        if (flush) state_d = mem_gnt ? DRAIN : IDLE;
        else if (mem_gnt) begin
          state_d  = WAIT;
          req_pc_d = pc;
          pc_inc   = 1'b1;
        end
      // a flushed read with no data yet still owes us one rvalid, swallowed in DRAIN
      WAIT:
        if (flush) state_d = mem_rvalid ? IDLE : DRAIN;
        else if (mem_rvalid) state_d = (fetch_en & space_push) ? REQ : IDLE;
      DRAIN: if (mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    instr_pc   = head[ADDR_W+DATA_W-1:DATA_W];
    instr_data = head[DATA_W-1:0];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= IDLE;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ADDR_W + DATA_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .din   ({req_pc_q, mem_rdata}),
    .pop   (pop),
    .dout  (head),
    .valid (instr_valid),
    .count (count)
  );
endmodule
